// File: rtl/imem_responder_if.sv
// ----------------------------------------------------------------------------
// imem_responder_if
// Fetch bus between the program-counter side (master) and the instruction
// memory responder (slave).
//   req_valid / req_ready / req_addr : fetch request channel (byte address)
//   rsp_valid / rsp_ready            : response handshake
//   rsp_data / rsp_addr / rsp_err    : instruction word, echoed address, error
// ----------------------------------------------------------------------------
interface imem_responder_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );
endinterface

// File: rtl/imem_responder.sv
// ----------------------------------------------------------------------------
// imem_responder
// Far end of the instruction fetch interface. Accepts fetch byte addresses,
// reads a word-addressed instruction memory through a LAT-stage registered
// pipeline, buffers results in a QD-entry fall-through queue and returns them
// in order together with the request address. A credit check on
// (in-flight + queued) guarantees the queue can never overflow, so the
// pipeline never has to stall. flush drops everything in flight.
// Ports:
//   clk      : clock, rising edge
//   clr      : synchronous active-high reset (memory contents are kept)
//   ld_en    : preload write enable
//   ld_idx   : preload word index
//   ld_data  : preload word
//   flush    : discard all in-flight and queued fetches
//   bus      : fetch bus, slave side (request and response channels)
// ----------------------------------------------------------------------------
module imem_responder #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int MEM_LG = 8,
    parameter int LAT    = 2,
    parameter int QD     = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ld_en,
    input  logic [MEM_LG-1:0] ld_idx,
    input  logic [DW-1:0]     ld_data,
    input  logic              flush,
    imem_responder_if.slave   bus
);

    localparam int CW    = $clog2(QD) + 1;
    localparam int PW    = (QD > 1) ? $clog2(QD) : 1;
    localparam int DEPTH = 1 << MEM_LG;
    localparam int HW    = AW - MEM_LG - 2;

    localparam logic [CW:0]   OCC_LIMIT = (CW + 1)'(QD);
    localparam logic [PW-1:0] PTR_LAST  = PW'(QD - 1);

    // Number of set bits in the pipeline valid vector (fetches in flight).
    function automatic logic [CW-1:0] count_ones(input logic [LAT-1:0] v);
        logic [CW-1:0] n;
        n = {CW{1'b0}};
        for (int i = 0; i < LAT; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    // Queue pointer increment that wraps modulo QD.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PTR_LAST) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Instruction storage
    logic [DW-1:0]     mem_r [DEPTH];

    // Read pipeline
    logic [LAT-1:0]    stage_valid_r;
    logic [LAT-1:0]    stage_err_r;
    logic [AW-1:0]     stage_addr_r [LAT];
    logic [DW-1:0]     stage_data_r [LAT];

    // Response queue
    logic [AW-1:0]     q_addr_r [QD];
    logic [DW-1:0]     q_data_r [QD];
    logic [QD-1:0]     q_err_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;

    // Combinational helpers
    logic              req_err_s;
    logic [MEM_LG-1:0] req_idx_s;
    logic [CW-1:0]     inflight_s;
    logic [CW:0]       occupancy_s;
    logic              req_ready_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              rsp_valid_s;

    // Address decode: misaligned or beyond the memory is an error fetch.
    always_comb begin
        req_idx_s = bus.req_addr[MEM_LG+1:2];
        if ((bus.req_addr[1:0] != 2'b00) ||
            (bus.req_addr[AW-1:MEM_LG+2] != {HW{1'b0}})) begin
            req_err_s = 1'b1;
        end else begin
            req_err_s = 1'b0;
        end
    end

    // Credit check: one extra bit on the sum so a full pipe+queue cannot wrap.
    always_comb begin
        inflight_s  = count_ones(stage_valid_r);
        occupancy_s = {1'b0, inflight_s} + {1'b0, count_r};
        if (clr || flush) begin
            req_ready_s = 1'b0;
        end else if (occupancy_s < OCC_LIMIT) begin
            req_ready_s = 1'b1;
        end else begin
            req_ready_s = 1'b0;
        end
    end

    // Handshake qualifiers; clr/flush already block accept through req_ready_s.
    always_comb begin
        accept_s    = bus.req_valid & req_ready_s;
        push_s      = stage_valid_r[LAT-1];
        rsp_valid_s = (count_r != {CW{1'b0}});
        pop_s       = rsp_valid_s & bus.rsp_ready;
    end

    // Response outputs come straight from the queue head; idle outputs read zero.
    always_comb begin
        bus.req_ready = req_ready_s;
        bus.rsp_valid = rsp_valid_s;
        if (rsp_valid_s) begin
            bus.rsp_data = q_data_r[rd_ptr_r];
            bus.rsp_addr = q_addr_r[rd_ptr_r];
            bus.rsp_err  = q_err_r[rd_ptr_r];
        end else begin
            bus.rsp_data = {DW{1'b0}};
            bus.rsp_addr = {AW{1'b0}};
            bus.rsp_err  = 1'b0;
        end
    end

    // Preload port; a read of the same index at this edge still sees the old word.
    always_ff @(posedge clk) begin
        if (!clr && ld_en) begin
            mem_r[ld_idx] <= ld_data;
        end
    end

    // Pipeline valid bits; clr and flush drop every fetch in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            stage_valid_r <= {LAT{1'b0}};
        end else if (flush) begin
            stage_valid_r <= {LAT{1'b0}};
        end else begin
            stage_valid_r[0] <= accept_s;
            for (int i = 1; i < LAT; i++) begin
                stage_valid_r[i] <= stage_valid_r[i-1];
            end
        end
    end

    // Pipeline payload; memory is read into stage 1, error fetches carry zero data.
    always_ff @(posedge clk) begin
        stage_addr_r[0] <= bus.req_addr;
        stage_err_r[0]  <= req_err_s;
        if (req_err_s) begin
            stage_data_r[0] <= {DW{1'b0}};
        end else begin
            stage_data_r[0] <= mem_r[req_idx_s];
        end
        for (int i = 1; i < LAT; i++) begin
            stage_addr_r[i] <= stage_addr_r[i-1];
            stage_err_r[i]  <= stage_err_r[i-1];
            stage_data_r[i] <= stage_data_r[i-1];
        end
    end

    // Queue pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; the last pipeline stage writes the tail entry.
    always_ff @(posedge clk) begin
        if (!clr && !flush && push_s) begin
            q_addr_r[wr_ptr_r] <= stage_addr_r[LAT-1];
            q_data_r[wr_ptr_r] <= stage_data_r[LAT-1];
            q_err_r[wr_ptr_r]  <= stage_err_r[LAT-1];
        end
    end

endmodule
